cla_pipe_adder: RTL and testbench

- Two-stage pipelined carry-lookahead adder/subtractor for the ALU datapath.
- Stage 1 forms bit-level propagate/generate and 4-bit group P/G, then registers them.
- Stage 2 resolves the group carries with two-level lookahead, forms the sum and flags, then registers the result.
- Valid/ready handshakes on both sides let the EX stage stall it without losing operands.

---
 rtl/cla_pipe_adder_if.sv | 34 +++
 rtl/cla_pipe_adder.sv | 205 ++++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pipe_adder_if
//  Brief    : Operand / result handshake bundle for the pipelined CLA adder.
//             master = producer/consumer side, slave = adder side.
//  Revision : 1.0  initial release
// ============================================================================
interface cla_pipe_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             carry_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, a, b, sub, carry_in, out_ready,
      input  in_ready, out_valid, sum, carry_out, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, sub, carry_in, out_ready,
      output in_ready, out_valid, sum, carry_out, overflow, zero
   );
endinterface
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pipe_adder
//  Brief    : Two-stage pipelined carry-lookahead adder/subtractor.
//             Stage 1 registers bit and 4-bit group propagate/generate;
//             stage 2 resolves carries with a two-level lookahead (groups of
//             four groups), forms sum and flags, and registers them.
//             Valid/ready on both sides; throughput one op per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module cla_pipe_adder #(
   parameter int WIDTH = 32,
   parameter int GROUP = 4      // only 4 is supported
) (
   input  wire logic        clk,
   input  wire logic        rst,   // synchronous, active-low
   cla_pipe_adder_if.slave  bus
);
   localparam int NG  = WIDTH / GROUP;   // number of 4-bit groups
   localparam int NS  = (NG + 3) / 4;    // number of super-groups (4 groups each)
   localparam int NGP = 4 * NS;          // group count padded to whole super-groups

   // ---------------------------------------------------------------- stage 1
   logic [WIDTH-1:0] w_bb;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_g;
   logic             w_cin;
   logic [NG-1:0]    w_gp;
   logic [NG-1:0]    w_gg;

   logic             r_s1Valid;
   logic [WIDTH-1:0] r_p;
   logic [WIDTH-1:0] r_g;
   logic             r_cin;
   logic             r_aMsb;
   logic             r_bbMsb;
   logic [NG-1:0]    r_gp;
   logic [NG-1:0]    r_gg;

   // ---------------------------------------------------------------- stage 2
   logic [NGP-1:0]   w_gpPad;
   logic [NGP-1:0]   w_ggPad;
   logic [NS-1:0]    w_sp;
   logic [NS-1:0]    w_sg;
   logic [NS:0]      w_sc;
   logic [NGP:0]     w_gc;
   logic [WIDTH-1:0] w_c;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_ovf;

   logic             r_s2Valid;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   // ---------------------------------------------------------------- handshake
   logic             w_adv1;
   logic             w_adv2;

   assign w_adv2       = !r_s2Valid || bus.out_ready;
   assign w_adv1       = !r_s1Valid || w_adv2;
   assign bus.in_ready = w_adv1;

   // Subtraction is A + ~B + 1, so carry_in is forced high and B inverted.
   assign w_bb  = bus.sub ? ~bus.b : bus.b;
   assign w_cin = bus.sub ? 1'b1 : bus.carry_in;
   assign w_p   = bus.a ^ w_bb;
   assign w_g   = bus.a & w_bb;

   generate
      for (genvar k = 0; k < NG; k++) begin : g_grpPg
         assign w_gp[k] = &w_p[GROUP*k +: GROUP];
         assign w_gg[k] = w_g[GROUP*k+3]
                        | (w_p[GROUP*k+3] & w_g[GROUP*k+2])
                        | (w_p[GROUP*k+3] & w_p[GROUP*k+2] & w_g[GROUP*k+1])
                        | (w_p[GROUP*k+3] & w_p[GROUP*k+2] & w_p[GROUP*k+1] & w_g[GROUP*k]);
      end
   endgenerate

   // Stage-1 register: capture conditioned operands when the pipe can advance.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s1Valid <= 1'b0;
         r_p       <= '0;
         r_g       <= '0;
         r_cin     <= 1'b0;
         r_aMsb    <= 1'b0;
         r_bbMsb   <= 1'b0;
         r_gp      <= '0;
         r_gg      <= '0;
      end else if (w_adv1) begin
         r_s1Valid <= bus.in_valid;
         r_p       <= w_p;
         r_g       <= w_g;
         r_cin     <= w_cin;
         r_aMsb    <= bus.a[WIDTH-1];
         r_bbMsb   <= w_bb[WIDTH-1];
         r_gp      <= w_gp;
         r_gg      <= w_gg;
      end
   end

   // Pad group P/G to a whole number of super-groups; padding never propagates.
   always_comb begin
      w_gpPad         = '0;
      w_ggPad         = '0;
      w_gpPad[NG-1:0] = r_gp;
      w_ggPad[NG-1:0] = r_gg;
   end

   generate
      for (genvar s = 0; s < NS; s++) begin : g_supPg
         assign w_sp[s] = &w_gpPad[4*s +: 4];
         assign w_sg[s] = w_ggPad[4*s+3]
                        | (w_gpPad[4*s+3] & w_ggPad[4*s+2])
                        | (w_gpPad[4*s+3] & w_gpPad[4*s+2] & w_ggPad[4*s+1])
                        | (w_gpPad[4*s+3] & w_gpPad[4*s+2] & w_gpPad[4*s+1] & w_ggPad[4*s]);
      end
   endgenerate

   // Level 2: super-group carries as flat sum-of-products of super P/G and cin.
   always_comb begin
      logic w_acc;
      logic w_term;
      w_sc    = '0;
      w_sc[0] = r_cin;
      for (int s = 0; s < NS; s++) begin
         w_acc = r_cin;
         for (int u = 0; u <= s; u++) w_acc = w_acc & w_sp[u];
         for (int t = 0; t <= s; t++) begin
            w_term = w_sg[t];
            for (int u = t + 1; u <= s; u++) w_term = w_term & w_sp[u];
            w_acc = w_acc | w_term;
         end
         w_sc[s+1] = w_acc;
      end
   end

   // Level 1: group carries inside each super-group, lookahead from its carry-in.
   always_comb begin
      logic w_acc;
      logic w_term;
      w_gc = '0;
      for (int s = 0; s < NS; s++) begin
         w_gc[4*s] = w_sc[s];
         for (int j = 0; j < 3; j++) begin
            w_acc = w_sc[s];
            for (int u = 0; u <= j; u++) w_acc = w_acc & w_gpPad[4*s+u];
            for (int t = 0; t <= j; t++) begin
               w_term = w_ggPad[4*s+t];
               for (int u = t + 1; u <= j; u++) w_term = w_term & w_gpPad[4*s+u];
               w_acc = w_acc | w_term;
            end
            w_gc[4*s+j+1] = w_acc;
         end
      end
      w_gc[NGP] = w_sc[NS];
   end

   // In-group bit carries ripple only across the four bits of a group.
   always_comb begin
      logic w_cc;
      w_c = '0;
      for (int k = 0; k < NG; k++) begin
         w_cc           = w_gc[k];
         w_c[GROUP*k]   = w_cc;
         for (int j = 0; j < GROUP - 1; j++) begin
            w_cc                = r_g[GROUP*k+j] | (r_p[GROUP*k+j] & w_cc);
            w_c[GROUP*k+j+1]    = w_cc;
         end
      end
   end

   assign w_sum  = r_p ^ w_c;
   assign w_cout = w_gc[NG];
   // Same as carry-into-MSB xor carry-out: operands agree in sign, result does not.
   assign w_ovf  = (r_aMsb ~^ r_bbMsb) & (r_aMsb ^ w_sum[WIDTH-1]);

   // Stage-2 register: result and flags, held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s2Valid <= 1'b0;
         r_sum     <= '0;
         r_cout    <= 1'b0;
         r_ovf     <= 1'b0;
         r_zero    <= 1'b0;
      end else if (w_adv2) begin
         r_s2Valid <= r_s1Valid;
         r_sum     <= w_sum;
         r_cout    <= w_cout;
         r_ovf     <= w_ovf;
         r_zero    <= (w_sum == '0);
      end
   end

   assign bus.out_valid = r_s2Valid;
   assign bus.sum       = r_sum;
   assign bus.carry_out = r_cout;
   assign bus.overflow  = r_ovf;
   assign bus.zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_pipe_adder
//  Brief    : Self-checking bench for cla_pipe_adder: directed corner cases,
//             back-pressure, random streaming against an arithmetic model,
//             and mid-operation reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cla_pipe_adder;
   localparam int W = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         co;
      logic         ov;
      logic         z;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cla_pipe_adder_if #(.WIDTH(W)) bus ();

   cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   res_t expQ[$];
   int   vecCount  = 0;
   int   missCount = 0;
   bit   monOn     = 1'b0;
   bit   prevStall = 1'b0;
   res_t prevOut;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic res_t refOp(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, input logic ci);
      res_t   r;
      longint ua, ub, ur, sa, sb, sr, lci;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lci = ci ? 64'sd1 : 64'sd0;
      if (s) begin
         ur   = ua - ub;
         sr   = sa - sb;
         r.co = (ua >= ub);
      end else begin
         ur   = ua + ub + lci;
         sr   = sa + sb + lci;
         r.co = ur[32];
      end
      r.sum = ur[W-1:0];
      r.ov  = (sr > SMAX) || (sr < SMIN);
      r.z   = (r.sum == '0);
      return r;
   endfunction

   // Monitor: model accepted ops, check every delivered result and stall stability.
   always @(negedge clk) begin
      res_t r;
      res_t cur;
      if (monOn && rst) begin
         cur = {bus.sum, bus.carry_out, bus.overflow, bus.zero};
         if (prevStall && bus.out_valid)
            checkVal("stall_stable", 64'(cur), 64'(prevOut));
         if (bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
               checkVal("unexpected_out", 64'd1, 64'd0);
            end else begin
               r = expQ.pop_front();
               checkVal("res_sum",  64'(bus.sum),       64'(r.sum));
               checkVal("res_cout", 64'(bus.carry_out), 64'(r.co));
               checkVal("res_ovf",  64'(bus.overflow),  64'(r.ov));
               checkVal("res_zero", 64'(bus.zero),      64'(r.z));
            end
         end
         prevStall = bus.out_valid && !bus.out_ready;
         prevOut   = cur;
         if (bus.in_valid && bus.in_ready)
            expQ.push_back(refOp(bus.a, bus.b, bus.sub, bus.carry_in));
      end else begin
         prevStall = 1'b0;
      end
   end

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic icin);
      bit acc;
      acc          = 1'b0;
      bus.in_valid = 1'b1;
      bus.a        = ia;
      bus.b        = ib;
      bus.sub      = isub;
      bus.carry_in = icin;
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!acc) checkVal("issue_timeout", 64'd0, 64'd1);
   endtask

   task automatic expectOut(input string tag, input logic [W-1:0] s,
                            input logic co, input logic ov, input logic z);
      checkVal({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      checkVal({tag, "_sum"},   64'(bus.sum),       64'(s));
      checkVal({tag, "_cout"},  64'(bus.carry_out), 64'(co));
      checkVal({tag, "_ovf"},   64'(bus.overflow),  64'(ov));
      checkVal({tag, "_zero"},  64'(bus.zero),      64'(z));
   endtask

   task automatic drainWait(input string tag);
      for (int n = 0; n < 300 && expQ.size() != 0; n++) begin
         @(posedge clk);
         #1;
      end
      checkVal(tag, 64'(expQ.size()), 64'd0);
   endtask

   // Main stimulus sequence.
   initial begin
      int nAcc;
      int sel;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sub       = 1'b0;
      bus.carry_in  = 1'b0;
      bus.out_ready = 1'b0;
      rst           = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkVal("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkVal("rst_sum",       64'(bus.sum),       64'd0);
      checkVal("rst_cout",      64'(bus.carry_out), 64'd0);
      checkVal("rst_ovf",       64'(bus.overflow),  64'd0);
      checkVal("rst_zero",      64'(bus.zero),      64'd0);
      rst   = 1'b1;
      monOn = 1'b1;
      checkVal("rst_in_ready",  64'(bus.in_ready),  64'd1);

      // Single add and latency
      bus.out_ready = 1'b1;
      issue(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
      checkVal("lat_early_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      expectOut("add", 32'h0000_0008, 1'b0, 1'b0, 1'b0);

      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      @(posedge clk); #1;
      expectOut("carry_chain", 32'h0000_0000, 1'b1, 1'b0, 1'b1);

      issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
      @(posedge clk); #1;
      expectOut("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      drainWait("directed_drain");

      // Back-pressure: three ops with the consumer stalled
      bus.out_ready = 1'b0;
      issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
      issue(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
      checkVal("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'b1;
      bus.a        = 32'h7FFF_FFFF;
      bus.b        = 32'h0000_0001;
      bus.sub      = 1'b0;
      bus.carry_in = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         checkVal("bp_hold_ready", 64'(bus.in_ready),  64'd0);
         checkVal("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      end
      bus.out_ready = 1'b1;
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      drainWait("bp_drain");

      // Random streaming with random valid/ready
      nAcc = 0;
      for (int n = 0; n < 3000 && nAcc < 100; n++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.out_ready = ($urandom_range(0, 9) < 7);
         sel = $urandom_range(0, 5);
         bus.a = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h8000_0000 : W'($urandom);
         sel = $urandom_range(0, 5);
         bus.b = (sel == 0) ? 32'h0000_0001 : (sel == 1) ? 32'h7FFF_FFFF : W'($urandom);
         bus.sub      = $urandom_range(0, 1) == 1;
         bus.carry_in = $urandom_range(0, 1) == 1;
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) nAcc++;
         @(posedge clk); #1;
      end
      checkVal("stream_count", 64'(nAcc), 64'd100);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drainWait("stream_drain");

      // Mid-operation reset with the pipe full
      bus.out_ready = 1'b0;
      issue(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0);
      issue(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0);
      checkVal("mr_full", 64'(bus.in_ready), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      expQ.delete();
      checkVal("mr_out_valid", 64'(bus.out_valid), 64'd0);
      checkVal("mr_sum",       64'(bus.sum),       64'd0);
      checkVal("mr_cout",      64'(bus.carry_out), 64'd0);
      checkVal("mr_ovf",       64'(bus.overflow),  64'd0);
      checkVal("mr_zero",      64'(bus.zero),      64'd0);
      rst           = 1'b1;
      bus.out_ready = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         checkVal("mr_no_stale", 64'(bus.out_valid), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
